vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, meaning visible pixels per line.
REQ-002 SHALL have parameters H_FRONT/H_SYNC/H_BACK, defaults 16/96/48, meaning horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameter V_ACTIVE, default 480, meaning visible lines per frame.
REQ-004 SHALL have parameters V_FRONT/V_SYNC/V_BACK, defaults 10/2/33, meaning vertical porch and sync widths in lines.
REQ-005 SHALL have parameter COLOR_BITS, default 1, meaning bits per colour channel.
REQ-006 SHALL have parameter SYNC_POL, default 0, meaning asserted sync level (0 = active-low).
REQ-007 SHALL have parameter LATENCY, default 2, range 1..8, meaning pixel-ticks from request to client colour.
REQ-008 SHALL have ports, one per line, clock and reset first:
  clock  in  1  sole clock, all logic rising-edge.
  reset  in  1  synchronous, active-high.
  pix_ce  in  1  pixel tick enable; all counters and pipeline advance only when 1.
  enable  in  1  1 = drive colour; 0 = force colour outputs to 0 (timing continues).
  pix_r/pix_g/pix_b  in  COLOR_BITS each  client colour for the request issued LATENCY ticks earlier.
  req_valid  out  1  current tick is inside active area.
  req_x  out  clog2(H_ACTIVE)  requested column.
  req_y  out  clog2(V_ACTIVE)  requested row.
  frame_start  out  1  one-clock pulse on the tick with h=0, v=0.
  vga_hsync/vga_vsync  out  1  sync outputs.
  vga_r/vga_g/vga_b  out  COLOR_BITS each  colour outputs.

Function
REQ-009 SHALL hold h_count 0..H_TOTAL-1, H_TOTAL = sum of four H params; increments on pix_ce, wraps to 0.
REQ-010 SHALL hold v_count 0..V_TOTAL-1; increments on the pix_ce tick where h_count wraps; wraps to 0 after V_TOTAL-1.
REQ-011 SHALL drive req_valid = (h_count < H_ACTIVE) and (v_count < V_ACTIVE), registered from counters, with req_x = h_count, req_y = v_count; req_x/req_y SHALL be 0 when req_valid = 0.
REQ-012 SHALL pulse frame_start for exactly one clock on the pix_ce cycle where h_count = 0 and v_count = 0.
REQ-013 SHALL compute raw hsync active when H_ACTIVE+H_FRONT <= h_count < H_ACTIVE+H_FRONT+H_SYNC; raw vsync likewise on v_count.
REQ-014 SHALL delay raw hsync, raw vsync and req_valid through a LATENCY+1 stage shift pipeline advancing only on pix_ce.
REQ-015 SHALL sample pix_r/g/b on the pix_ce tick LATENCY ticks after the matching request, and present it on vga_r/g/b one tick later, aligned with the delayed syncs.
REQ-016 SHALL drive vga_r/g/b = 0 when the delayed req_valid = 0 or enable = 0, regardless of pix_* inputs.
REQ-017 SHALL drive vga_hsync/vga_vsync = SYNC_POL while the delayed raw sync is active, else ~SYNC_POL.
REQ-018 SHALL hold every register and output unchanged on clocks where pix_ce = 0 (frame_start = 0 on those clocks).
REQ-019 SHALL sample enable per tick; toggling mid-line SHALL affect colour only, never sync timing.

Reset
REQ-020 SHALL, while reset = 1 on a rising edge, clear h_count, v_count and all pipeline stages to 0 / inactive, regardless of pix_ce.
REQ-021 SHALL hold after reset: vga_hsync = vga_vsync = ~SYNC_POL, vga_r/g/b = 0, req_valid = 0, req_x = req_y = 0, frame_start = 0.
REQ-022 SHALL restart from h = 0, v = 0 on the first pix_ce tick after reset deasserts, with frame_start pulsing on that tick; reset mid-frame SHALL abandon the frame without a partial sync pulse after release.

Verification
REQ-023 Defaults, pix_ce = 1, reset released at T0 -> frame_start at T0+1 and every 420000 clocks; hsync low 96 clocks per 800; vsync low 1600 clocks per frame.
REQ-024 pix_ce toggling 1/0 -> all periods double (1600-clock line, 840000-clock frame), outputs frozen on ce = 0 clocks.
REQ-025 H = 4/1/1/1, V = 3/1/1/1, LATENCY = 3, pix_r = req_x[0] echoed with 3-tick delay -> vga_r shows 0,1,0,1 aligned exactly with delayed active, 0 during blanking.
REQ-026 pix_r/g/b held all-ones, enable = 0 for one line -> vga_r/g/b = 0 across that line; syncs unchanged.
REQ-027 SYNC_POL = 1 -> idle syncs 0, pulses high, same widths as REQ-023.
REQ-028 reset asserted at h = 700, v = 200 for 3 clocks -> outputs at reset values, next frame_start one tick after release, no stray hsync pulse.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator with a latency-matched client colour path
// Counters issue pixel requests; syncs are delayed so they line up with the client's colour reply.
module vga_timing_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int COLOR_BITS = 1,
  parameter bit SYNC_POL   = 1'b0,
  parameter int LATENCY    = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        pix_ce,
  input  logic                        enable,
  input  logic [COLOR_BITS-1:0]       pix_r,
  input  logic [COLOR_BITS-1:0]       pix_g,
  input  logic [COLOR_BITS-1:0]       pix_b,
  output logic                        req_valid,
  output logic [$clog2(H_ACTIVE)-1:0] req_x,
  output logic [$clog2(V_ACTIVE)-1:0] req_y,
  output logic                        frame_start,
  output logic                        vga_hsync,
  output logic                        vga_vsync,
  output logic [COLOR_BITS-1:0]       vga_r,
  output logic [COLOR_BITS-1:0]       vga_g,
  output logic [COLOR_BITS-1:0]       vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);
  localparam int XW = $clog2(H_ACTIVE);
  localparam int YW = $clog2(V_ACTIVE);

  localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_ON  = HW'(H_ACTIVE + H_FRONT);
  localparam logic [HW-1:0] H_SYNC_OFF = HW'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_ON  = VW'(V_ACTIVE + V_FRONT);
  localparam logic [VW-1:0] V_SYNC_OFF = VW'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [HW-1:0]         r_h;
  logic [VW-1:0]         r_v;
  logic                  r_req_valid;
  logic [XW-1:0]         r_req_x;
  logic [YW-1:0]         r_req_y;
  logic                  r_frame_start;
  // Sync stage 0 is loaded alongside req_valid, so syncs carry one extra stage.
  logic [LATENCY+1:0]    r_hs_d;
  logic [LATENCY+1:0]    r_vs_d;
  logic [LATENCY:0]      r_val_d;
  logic                  r_en;
  logic [COLOR_BITS-1:0] r_col_r;
  logic [COLOR_BITS-1:0] r_col_g;
  logic [COLOR_BITS-1:0] r_col_b;

  logic w_h_last;
  logic w_v_last;
  logic w_active;
  logic w_hs_raw;
  logic w_vs_raw;
  logic w_origin;

  assign w_h_last = (r_h == H_LAST);
  assign w_v_last = (r_v == V_LAST);
  assign w_active = (r_h < H_ACT) && (r_v < V_ACT);
  assign w_hs_raw = (r_h >= H_SYNC_ON) && (r_h < H_SYNC_OFF);
  assign w_vs_raw = (r_v >= V_SYNC_ON) && (r_v < V_SYNC_OFF);
  assign w_origin = (r_h == '0) && (r_v == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_h           <= '0;
      r_v           <= '0;
      r_req_valid   <= 1'b0;
      r_req_x       <= '0;
      r_req_y       <= '0;
      r_frame_start <= 1'b0;
      r_hs_d        <= '0;
      r_vs_d        <= '0;
      r_val_d       <= '0;
      r_en          <= 1'b0;
      r_col_r       <= '0;
      r_col_g       <= '0;
      r_col_b       <= '0;
    end else begin
      r_frame_start <= pix_ce & w_origin;
      if (pix_ce) begin
        r_h <= w_h_last ? '0 : r_h + 1'b1;
        if (w_h_last) begin
          r_v <= w_v_last ? '0 : r_v + 1'b1;
        end
        r_req_valid <= w_active;
        r_req_x     <= w_active ? r_h[XW-1:0] : '0;
        r_req_y     <= w_active ? r_v[YW-1:0] : '0;
        r_hs_d      <= {r_hs_d[LATENCY:0], w_hs_raw};
        r_vs_d      <= {r_vs_d[LATENCY:0], w_vs_raw};
        r_val_d     <= {r_val_d[LATENCY-1:0], r_req_valid};
        // Client reply for the request now leaving stage LATENCY-1 is on pix_* this tick.
        r_en    <= enable;
        r_col_r <= pix_r;
        r_col_g <= pix_g;
        r_col_b <= pix_b;
      end
    end
  end

  assign req_valid   = r_req_valid;
  assign req_x       = r_req_x;
  assign req_y       = r_req_y;
  assign frame_start = r_frame_start;
  assign vga_hsync   = r_hs_d[LATENCY+1] ? SYNC_POL : ~SYNC_POL;
  assign vga_vsync   = r_vs_d[LATENCY+1] ? SYNC_POL : ~SYNC_POL;
  assign vga_r       = (r_val_d[LATENCY] & r_en) ? r_col_r : '0;
  assign vga_g       = (r_val_d[LATENCY] & r_en) ? r_col_g : '0;
  assign vga_b       = (r_val_d[LATENCY] & r_en) ? r_col_b : '0;

endmodule
